// File: rtl/studio2_pkg.sv
// studio2_pkg: shared types and memory-map constants for the Studio II memory
// arbiter.
//   state_t  - arbiter FSM states
//   req_id_t - requester identity (loader, DMA, CPU)
//   region_t - decoded address region
//   *_BASE / *_LIMIT - inclusive 12-bit bounds of each region in the 4 KiB map
//   in_range() - inclusive bounds test used by the decoder
package studio2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RQ_NONE = 2'd0,
        RQ_LD   = 2'd1,
        RQ_DMA  = 2'd2,
        RQ_CPU  = 2'd3
    } req_id_t;

    typedef enum logic [2:0] {
        RG_ROM      = 3'd0,
        RG_CART     = 3'd1,
        RG_RAM      = 3'd2,
        RG_MULTI    = 3'd3,
        RG_MIRROR   = 3'd4,
        RG_UNMAPPED = 3'd5
    } region_t;

    localparam logic [11:0] ROM_BASE     = 12'h000;
    localparam logic [11:0] ROM_LIMIT    = 12'h3FF;
    localparam logic [11:0] CART_BASE    = 12'h400;
    localparam logic [11:0] CART_LIMIT   = 12'h7FF;
    localparam logic [11:0] RAM_BASE     = 12'h800;
    localparam logic [11:0] RAM_LIMIT    = 12'h9FF;
    localparam logic [11:0] MC_LO_BASE   = 12'hA00;
    localparam logic [11:0] MC_LO_LIMIT  = 12'hBFF;
    localparam logic [11:0] MIRROR_BASE  = 12'hC00;
    localparam logic [11:0] MIRROR_LIMIT = 12'hDFF;
    localparam logic [11:0] MC_HI_BASE   = 12'hE00;
    localparam logic [11:0] MC_HI_LIMIT  = 12'hFFF;

    function automatic logic in_range(input logic [11:0] a,
                                      input logic [11:0] base,
                                      input logic [11:0] limit);
        return (a >= base) && (a <= limit);
    endfunction

endpackage

// File: rtl/studio2_addr_dec.sv
// studio2_addr_dec: combinational address decoder for the Studio II map.
// Build option: STUDIO2_MULTICART_EN maps A00-BFF and E00-FFF to backing RAM;
// without it those ranges decode as unmapped.
// Ports:
//   addr    in  16  requester address
//   req_id  in  2   requester (req_id_t encoding)
//   wr      in  1   access is a write
//   region  out 3   decoded region (region_t encoding)
//   phys    out 12  backing-RAM address (mirror folded onto 800-9FF)
//   we_ok   out 1   write is allowed to reach the RAM
//   ram_sel out 1   region is served by the backing RAM port
module studio2_addr_dec
    import studio2_pkg::*;
(
    input  logic [15:0] addr,
    input  logic [1:0]  req_id,
    input  logic        wr,
    output logic [2:0]  region,
    output logic [11:0] phys,
    output logic        we_ok,
    output logic        ram_sel
);

`ifdef STUDIO2_MULTICART_EN
    localparam region_t MC_REGION = RG_MULTI;
`else
    localparam region_t MC_REGION = RG_UNMAPPED;
`endif

    region_t     rg;
    req_id_t     rid;
    logic [11:0] off;
    logic        mc_hit;

    assign rid    = req_id_t'(req_id);
    assign off    = addr[11:0];
    assign mc_hit = in_range(off, MC_LO_BASE, MC_LO_LIMIT) ||
                    in_range(off, MC_HI_BASE, MC_HI_LIMIT);

    always_comb begin
        rg      = RG_UNMAPPED;
        phys    = off;
        we_ok   = 1'b0;
        ram_sel = 1'b0;

        if (addr[15:12] == 4'h0) begin
            if (in_range(off, ROM_BASE, ROM_LIMIT)) begin
                rg = RG_ROM;
            end else if (in_range(off, CART_BASE, CART_LIMIT)) begin
                rg = RG_CART;
            end else if (in_range(off, RAM_BASE, RAM_LIMIT)) begin
                rg = RG_RAM;
            end else if (in_range(off, MIRROR_BASE, MIRROR_LIMIT)) begin
                rg   = RG_MIRROR;
                phys = {3'b100, off[8:0]};
            end else if (mc_hit) begin
                rg = MC_REGION;
            end
        end

        // Cartridge space is write-protected for the CPU but filled by the loader.
        case (rg)
            RG_CART: begin
                ram_sel = 1'b1;
                we_ok   = (rid == RQ_LD);
            end
            RG_RAM, RG_MIRROR, RG_MULTI: begin
                ram_sel = 1'b1;
                we_ok   = (rid == RQ_LD) || (rid == RQ_CPU);
            end
            default: begin
                ram_sel = 1'b0;
                we_ok   = 1'b0;
            end
        endcase

        we_ok = we_ok & wr;
    end

    assign region = rg;

endmodule

// File: rtl/studio2_mem_arb.sv
// studio2_mem_arb: three-way memory arbiter for the Studio II (CDP1802 CPU,
// Pixie DMA, cartridge loader) in front of a system ROM and a backing RAM.
// Priority loader > DMA > CPU, with DMA bursts capped at DMA_BURST_MAX while
// the CPU is waiting. Each grant takes IDLE/RESP -> ACCESS -> RESP; data and
// completion strobes appear in RESP, two cycles after the grant.
// Build option: STUDIO2_MULTICART_EN (see studio2_addr_dec).
// Ports:
//   clk, resetq                      clock, synchronous active-low reset
//   cpu_rd/wr/a/d, cpu_q/valid/done/wait  CPU strobes, data and stall
//   dma_req/a, dma_ack/q/valid       Pixie DMA request, grant pulse, data
//   ld_active/wr/a/d                 cartridge download write port
//   rom_a, rom_q                     system ROM, 1-cycle synchronous read
//   mem_ce/we/a/d, mem_q             backing RAM, 1-cycle synchronous read
//
// state  | meaning
// IDLE   | no transaction; grant chosen from pending requests
// ACCESS | memory address/strobes driven for the latched winner
// RESP   | read data / done strobe returned; may re-grant back-to-back
module studio2_mem_arb
    import studio2_pkg::*;
#(
    parameter int unsigned DMA_BURST_MAX = 8,
    parameter logic [7:0]  UNMAPPED_VAL  = 8'hFF
)(
    input  logic        clk,
    input  logic        resetq,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    output logic [7:0]  cpu_q,
    output logic        cpu_valid,
    output logic        cpu_done,
    output logic        cpu_wait,
    input  logic        dma_req,
    input  logic [15:0] dma_a,
    output logic        dma_ack,
    output logic [7:0]  dma_q,
    output logic        dma_valid,
    input  logic        ld_active,
    input  logic        ld_wr,
    input  logic [11:0] ld_a,
    input  logic [7:0]  ld_d,
    output logic [9:0]  rom_a,
    input  logic [7:0]  rom_q,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [11:0] mem_a,
    output logic [7:0]  mem_d,
    input  logic [7:0]  mem_q
);

    localparam int CNT_W = $clog2(DMA_BURST_MAX + 1);

    state_t      state, state_nx;
    req_id_t     gnt, pick;
    region_t     region_r;
    logic        take;

    logic        ld_pend;
    logic [11:0] ld_a_r;
    logic [7:0]  ld_d_r;

    logic [CNT_W-1:0] dma_cnt;
    logic        burst_full;

    logic        cpu_req, cpu_pend, cpu_slot;
    logic [15:0] sel_addr;
    logic [7:0]  sel_d;
    logic        sel_wr;

    logic [2:0]  dec_region;
    logic [11:0] dec_phys;
    logic        dec_we, dec_ram_sel;

    logic        wr_r, ce_r, we_r;
    logic [9:0]  rom_a_r;
    logic [11:0] mem_a_r;
    logic [7:0]  mem_d_r;
    logic [7:0]  cpu_q_r, dma_q_r, rd_data;
    logic        in_resp;

    // The CPU holds its strobe through the RESP cycle of its own access, so it
    // must not look pending there or it would be serviced twice.
    assign cpu_req    = cpu_rd | cpu_wr;
    assign cpu_pend   = cpu_req && !(state == ST_RESP && gnt == RQ_CPU);
    assign cpu_slot   = cpu_pend && !ld_active;
    assign burst_full = (dma_cnt >= CNT_W'(DMA_BURST_MAX));

    always_comb begin
        pick = RQ_NONE;
        if (ld_pend) begin
            pick = RQ_LD;
        end else if (dma_req && !(cpu_slot && burst_full)) begin
            pick = RQ_DMA;
        end else if (cpu_slot) begin
            pick = RQ_CPU;
        end
    end

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick != RQ_NONE) begin
                    state_nx = ST_ACCESS;
                    take     = 1'b1;
                end
            end
            ST_ACCESS: state_nx = ST_RESP;
            ST_RESP: begin
                if (pick != RQ_NONE) begin
                    state_nx = ST_ACCESS;
                    take     = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_addr = cpu_a;
        sel_d    = cpu_d;
        sel_wr   = cpu_wr;
        case (pick)
            RQ_LD: begin
                sel_addr = {4'h0, ld_a_r};
                sel_d    = ld_d_r;
                sel_wr   = 1'b1;
            end
            RQ_DMA: begin
                sel_addr = dma_a;
                sel_wr   = 1'b0;
            end
            default: ;
        endcase
    end

    studio2_addr_dec u_dec (
        .addr    (sel_addr),
        .req_id  (pick),
        .wr      (sel_wr),
        .region  (dec_region),
        .phys    (dec_phys),
        .we_ok   (dec_we),
        .ram_sel (dec_ram_sel)
    );

    assign in_resp = resetq && (state == ST_RESP);

    always_comb begin
        case (region_r)
            RG_ROM:                               rd_data = rom_q;
            RG_CART, RG_RAM, RG_MIRROR, RG_MULTI: rd_data = mem_q;
            default:                              rd_data = UNMAPPED_VAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            state    <= ST_IDLE;
            gnt      <= RQ_NONE;
            region_r <= RG_UNMAPPED;
            ld_pend  <= 1'b0;
            ld_a_r   <= '0;
            ld_d_r   <= '0;
            dma_cnt  <= '0;
            wr_r     <= 1'b0;
            ce_r     <= 1'b0;
            we_r     <= 1'b0;
            rom_a_r  <= '0;
            mem_a_r  <= '0;
            mem_d_r  <= '0;
            cpu_q_r  <= 8'h00;
            dma_q_r  <= 8'h00;
        end else begin
            state <= state_nx;
            ce_r  <= 1'b0;
            we_r  <= 1'b0;

            // A new loader write arriving on the grant cycle wins over the clear.
            if (ld_active && ld_wr) begin
                ld_pend <= 1'b1;
                ld_a_r  <= ld_a;
                ld_d_r  <= ld_d;
            end else if (take && pick == RQ_LD) begin
                ld_pend <= 1'b0;
            end

            if (take) begin
                gnt      <= pick;
                wr_r     <= sel_wr;
                region_r <= region_t'(dec_region);
                rom_a_r  <= sel_addr[9:0];
                mem_a_r  <= dec_phys;
                mem_d_r  <= sel_d;
                ce_r     <= dec_ram_sel;
                we_r     <= dec_we;
                if (pick == RQ_CPU) begin
                    dma_cnt <= '0;
                end else if (pick == RQ_DMA && cpu_req && !burst_full) begin
                    dma_cnt <= dma_cnt + 1'b1;
                end
            end

            if (state == ST_RESP && gnt == RQ_CPU && !wr_r) cpu_q_r <= rd_data;
            if (state == ST_RESP && gnt == RQ_DMA)          dma_q_r <= rd_data;
        end
    end

    // Strobes are gated with resetq so an access caught by reset mid-cycle
    // never reaches the RAM or the requester.
    assign mem_ce    = ce_r & resetq;
    assign mem_we    = we_r & resetq;
    assign mem_a     = mem_a_r;
    assign mem_d     = mem_d_r;
    assign rom_a     = rom_a_r;

    assign cpu_valid = in_resp && (gnt == RQ_CPU) && !wr_r;
    assign cpu_done  = in_resp && (gnt == RQ_CPU) && wr_r;
    assign dma_valid = in_resp && (gnt == RQ_DMA);
    assign dma_ack   = resetq && (state == ST_ACCESS) && (gnt == RQ_DMA);

    assign cpu_q     = cpu_valid ? rd_data : cpu_q_r;
    assign dma_q     = dma_valid ? rd_data : dma_q_r;

    assign cpu_wait  = !resetq || ld_active ||
                       (cpu_req && !(state == ST_RESP && gnt == RQ_CPU));

endmodule

// File: tb/tb_studio2_mem_arb.sv
// Directed self-checking bench for studio2_mem_arb with behavioural ROM/RAM.
module tb_studio2_mem_arb;

`ifdef STUDIO2_MULTICART_EN
    localparam logic [7:0] EXP_A00 = 8'h12;
`else
    localparam logic [7:0] EXP_A00 = 8'hFF;
`endif

    logic        clk = 1'b0;
    logic        resetq;
    logic        cpu_rd, cpu_wr;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic [7:0]  cpu_q;
    logic        cpu_valid, cpu_done, cpu_wait;
    logic        dma_req;
    logic [15:0] dma_a;
    logic        dma_ack, dma_valid;
    logic [7:0]  dma_q;
    logic        ld_active, ld_wr;
    logic [11:0] ld_a;
    logic [7:0]  ld_d;
    logic [9:0]  rom_a;
    logic [7:0]  rom_q;
    logic        mem_ce, mem_we;
    logic [11:0] mem_a;
    logic [7:0]  mem_d;
    logic [7:0]  mem_q;

    logic        ram_init;
    logic [7:0]  ram [0:4095];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    studio2_mem_arb dut (
        .clk       (clk),
        .resetq    (resetq),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_a     (cpu_a),
        .cpu_d     (cpu_d),
        .cpu_q     (cpu_q),
        .cpu_valid (cpu_valid),
        .cpu_done  (cpu_done),
        .cpu_wait  (cpu_wait),
        .dma_req   (dma_req),
        .dma_a     (dma_a),
        .dma_ack   (dma_ack),
        .dma_q     (dma_q),
        .dma_valid (dma_valid),
        .ld_active (ld_active),
        .ld_wr     (ld_wr),
        .ld_a      (ld_a),
        .ld_d      (ld_d),
        .rom_a     (rom_a),
        .rom_q     (rom_q),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .mem_q     (mem_q)
    );

    // ROM content is a fixed pattern: low address byte xor 8'h3C.
    always @(posedge clk) begin
        rom_q <= rom_a[7:0] ^ 8'h3C;
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h812] <= 8'h5A;
            ram[12'h900] <= 8'h9C;
            ram[12'hA00] <= 8'h12;
        end else if (mem_ce) begin
            if (mem_we) ram[mem_a] <= mem_d;
            mem_q <= ram[mem_a];
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one CPU access from an idle arbiter and wait for its strobe.
    task automatic cpu_op(input logic wr, input logic [15:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] q, output logic wt,
                          output logic wt_acc, output logic we_seen, output logic [11:0] we_a);
        lat = -1; q = 8'h00; wt = 1'b1; wt_acc = 1'b0; we_seen = 1'b0; we_a = 12'h000;
        @(posedge clk); #1;
        cpu_a = a; cpu_d = d; cpu_rd = !wr; cpu_wr = wr;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 1) wt_acc = cpu_wait;
            if (mem_we) begin
                we_seen = 1'b1;
                we_a    = mem_a;
            end
            if (wr ? cpu_done : cpu_valid) begin
                lat = k;
                q   = cpu_q;
                wt  = cpu_wait;
                break;
            end
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    int          lat, ack_k, val_k, run, ncpu;
    int          runs [0:1];
    logic [7:0]  q, qb;
    logic        wt, wt_acc, we_seen, wait_all, vseen, bad_we;
    logic [11:0] we_a;

    initial begin
        resetq = 1'b0; ram_init = 1'b1;
        cpu_rd = 0; cpu_wr = 0; cpu_a = 0; cpu_d = 0;
        dma_req = 0; dma_a = 0;
        ld_active = 0; ld_wr = 0; ld_a = 0; ld_d = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_valid", 16'(cpu_valid), 16'h0);
        check("rst_cpu_done",  16'(cpu_done),  16'h0);
        check("rst_dma_ack",   16'(dma_ack),   16'h0);
        check("rst_dma_valid", 16'(dma_valid), 16'h0);
        check("rst_mem_ce_we", 16'({mem_ce, mem_we}), 16'h0);
        check("rst_cpu_q",     16'(cpu_q),     16'h00);
        check("rst_dma_q",     16'(dma_q),     16'h00);
        check("rst_mem_a",     16'(mem_a),     16'h000);
        check("rst_rom_a",     16'(rom_a),     16'h000);
        check("rst_cpu_wait",  16'(cpu_wait),  16'h1);
        @(posedge clk); #1;
        ram_init = 1'b0; resetq = 1'b1;
        @(posedge clk);

        // CPU read of RAM with two-cycle latency
        cpu_op(1'b0, 16'h0812, 8'h00, lat, q, wt, wt_acc, we_seen, we_a);
        check("rd812_lat",      16'(lat),    16'd2);
        check("rd812_q",        16'(q),      16'h5A);
        check("rd812_wait_rsp", 16'(wt),     16'h0);
        check("rd812_wait_acc", 16'(wt_acc), 16'h1);

        // mirror write then read through the base range
        cpu_op(1'b1, 16'h0C05, 8'h33, lat, q, wt, wt_acc, we_seen, we_a);
        check("wrC05_lat",  16'(lat),     16'd2);
        check("wrC05_we",   16'(we_seen), 16'h1);
        check("wrC05_phys", 16'(we_a),    16'h805);
        cpu_op(1'b0, 16'h0805, 8'h00, lat, q, wt, wt_acc, we_seen, we_a);
        check("rd805_q", 16'(q), 16'h33);

        // write-protected cartridge space
        cpu_op(1'b1, 16'h0400, 8'h77, lat, q, wt, wt_acc, we_seen, we_a);
        check("wr400_done", 16'(lat),       16'd2);
        check("wr400_nowe", 16'(we_seen),   16'h0);
        check("wr400_ram",  16'(ram[12'h400]), 16'h00);

        // system ROM read: 0x23 ^ 0x3C
        cpu_op(1'b0, 16'h0123, 8'h00, lat, q, wt, wt_acc, we_seen, we_a);
        check("rd123_rom", 16'(q), 16'h1F);

        // unmapped and multicart
        cpu_op(1'b0, 16'h1000, 8'h00, lat, q, wt, wt_acc, we_seen, we_a);
        check("rd1000_lat", 16'(lat), 16'd2);
        check("rd1000_q",   16'(q),   16'hFF);
        cpu_op(1'b1, 16'h1234, 8'h55, lat, q, wt, wt_acc, we_seen, we_a);
        check("wr1234_done", 16'(lat),     16'd2);
        check("wr1234_nowe", 16'(we_seen), 16'h0);
        cpu_op(1'b0, 16'h0A00, 8'h00, lat, q, wt, wt_acc, we_seen, we_a);
        check("rdA00_q", 16'(q), 16'(EXP_A00));

        // single DMA read
        ack_k = -1; val_k = -1;
        @(posedge clk); #1;
        dma_a = 16'h0900; dma_req = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dma_ack) begin
                ack_k   = k;
                dma_req = 1'b0;
            end
            if (dma_valid) begin
                val_k = k;
                q     = dma_q;
                break;
            end
        end
        dma_req = 1'b0;
        check("dma_ack_k",   16'(ack_k), 16'd1);
        check("dma_valid_k", 16'(val_k), 16'd2);
        check("dma_q",       16'(q),     16'h9C);

        // DMA and CPU both held: 8 DMA grants then one CPU grant, twice
        run = 0; ncpu = 0; qb = 8'h00; runs[0] = 0; runs[1] = 0;
        @(posedge clk); #1;
        cpu_a = 16'h0812; cpu_rd = 1'b1; dma_a = 16'h0900; dma_req = 1'b1;
        for (int k = 0; k < 200 && ncpu < 2; k++) begin
            @(negedge clk);
            if (dma_ack) run++;
            if (cpu_valid) begin
                runs[ncpu] = run;
                qb   = cpu_q;
                run  = 0;
                ncpu++;
            end
        end
        cpu_rd = 1'b0; dma_req = 1'b0;
        check("burst_cpu_grants", 16'(ncpu),    16'd2);
        check("burst_run0",       16'(runs[0]), 16'd8);
        check("burst_run1",       16'(runs[1]), 16'd8);
        check("burst_cpu_q",      16'(qb),      16'h5A);
        repeat (4) @(posedge clk);
        check("burst_dma_q", 16'(dma_q), 16'h9C);

        // loader writes while the CPU waits
        @(posedge clk); #1;
        ld_active = 1'b1;
        @(posedge clk); #1;
        cpu_a = 16'h0405; cpu_rd = 1'b1;
        ld_a = 12'h405; ld_d = 8'hD1; ld_wr = 1'b1;
        @(posedge clk); #1;
        ld_a = 12'h100; ld_d = 8'hEE;
        @(posedge clk); #1;
        ld_wr = 1'b0;
        wait_all = 1'b1; vseen = 1'b0; bad_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            wait_all = wait_all & cpu_wait;
            vseen    = vseen | cpu_valid;
            if (mem_we && mem_a == 12'h100) bad_we = 1'b1;
        end
        check("ld_wait_held",  16'(wait_all),      16'h1);
        check("ld_no_cpu_rsp", 16'(vseen),         16'h0);
        check("ld_ram405",     16'(ram[12'h405]),  16'hD1);
        check("ld_rom_prot",   16'({bad_we, ram[12'h100]}), 16'h000);
        @(posedge clk); #1;
        ld_active = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cpu_valid) begin
                lat = k;
                q   = cpu_q;
                break;
            end
        end
        cpu_rd = 1'b0;
        check("ld_cpu_served", 16'(lat >= 0), 16'h1);
        check("ld_cpu_q",      16'(q),        16'hD1);

        // loader strobe without ld_active is ignored
        @(posedge clk); #1;
        ld_a = 12'h406; ld_d = 8'hAB; ld_wr = 1'b1;
        @(posedge clk); #1;
        ld_wr = 1'b0;
        repeat (5) @(posedge clk);
        check("ld_inactive", 16'(ram[12'h406]), 16'h00);

        // reset during ACCESS of a CPU write aborts it
        @(posedge clk); #1;
        cpu_a = 16'h0810; cpu_d = 8'h44; cpu_wr = 1'b1;
        @(posedge clk); #1;
        check("abort_in_access", 16'(mem_we), 16'h1);
        resetq = 1'b0;
        @(negedge clk);
        check("abort_we_gated", 16'({mem_ce, mem_we}), 16'h0);
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        @(negedge clk);
        check("abort_done",   16'(cpu_done), 16'h0);
        check("abort_cpu_q",  16'(cpu_q),    16'h00);
        check("abort_mem_a",  16'(mem_a),    16'h000);
        check("abort_wait",   16'(cpu_wait), 16'h1);
        @(posedge clk); #1;
        resetq = 1'b1;
        vseen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vseen = vseen | cpu_done | mem_we;
        end
        check("abort_no_late", 16'(vseen),         16'h0);
        check("abort_ram810",  16'(ram[12'h810]),  16'h00);

        cpu_op(1'b0, 16'h0812, 8'h00, lat, q, wt, wt_acc, we_seen, we_a);
        check("post_rst_rd", 16'(q), 16'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
